// File: rtl/dram_resp.sv
// dram_resp: word-addressed DRAM responder with pipelined reads, counters and OOR flag
// Optional build macro DRAM_RESP_FWD_EN: same-cycle same-address read returns the write data.
module dram_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_DEPTH  = 196608,
  parameter int RD_LAT     = 1,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  dram_valid,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic                  err_oor
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("dram_resp: RD_LAT must be 1..4");
  end
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [RD_LAT-1:0]     vld_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LAT];
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                  err_q, err_d;
  logic                  rd_in, wr_in, wr_ok, hit;
  logic [DATA_WIDTH-1:0] rd_word;
  // range decode, collision detect and the word entering the read pipeline
  always_comb begin
    rd_in = {1'b0, addr_in} < DEPTH;
    wr_in = {1'b0, addr_out} < DEPTH;
    wr_ok = dram_en_wr && wr_in;
`ifdef DRAM_RESP_FWD_EN
    hit = wr_ok && (addr_out == addr_in);
`else
    hit = 1'b0;
`endif
    rd_word = !rd_in ? '0 : hit ? data_out : mem_q[addr_in];
  end
  // backing store has no reset so the image survives srstn
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[addr_out] <= data_out;
  end
  // read shift pipeline; data stages only load when their valid advances
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q[0] <= dram_en_rd;
      if (dram_en_rd) dat_q[0] <= rd_word;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end
  // saturating counters and sticky error; clear wins over any same-cycle update
  always_comb begin
    rd_cnt_d = clr_cnt ? '0 : (dram_en_rd && rd_cnt_q != '1) ? rd_cnt_q + 1'b1 : rd_cnt_q;
    wr_cnt_d = clr_cnt ? '0 : (dram_en_wr && wr_cnt_q != '1) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    err_d    = !clr_cnt && (err_q || (dram_en_rd && !rd_in) || (dram_en_wr && !wr_in));
  end
  // status registers
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end
  assign data_in    = dat_q[RD_LAT-1];
  assign dram_valid = vld_q[RD_LAT-1];
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;
  assign err_oor    = err_q;
endmodule

// File: doc/dram_resp.md
Name: dram_resp

Overview:
- Responder (memory side) of the layer-block DRAM interface; serves the read/write requests issued by relu and the other layer engines.
- Provides one read port and one write port on a word-addressed backing store. Read data is returned after a fixed pipeline latency, together with a valid strobe.
- Keeps saturating access counters and a sticky out-of-range error flag for bench and debug visibility.
- Sits between the layer engines and the testbench/host memory image; addresses follow the global map: params 0, biases 61504, fmap 131072.

Parameters:
- DATA_WIDTH, 32, word width of read and write data.
- ADDR_WIDTH, 18, word address width.
- MEM_DEPTH, 196608, number of implemented words. Valid addresses are 0..MEM_DEPTH-1.
- RD_LAT, 1, read latency in cycles. Legal range 1..4.
- CNT_WIDTH, 24, width of the access counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- srstn  input  1  asynchronous, active-low reset.
- dram_en_rd  input  1  read request this cycle.
- addr_in  input  ADDR_WIDTH  read address, sampled when dram_en_rd=1.
- dram_en_wr  input  1  write request this cycle.
- addr_out  input  ADDR_WIDTH  write address, sampled when dram_en_wr=1.
- data_out  input  DATA_WIDTH  write data (client's output), sampled when dram_en_wr=1.
- data_in  output  DATA_WIDTH  read data (client's input).
- dram_valid  output  1  data_in holds the response to the read issued RD_LAT cycles earlier.
- clr_cnt  input  1  synchronous clear of the counters and err_oor.
- rd_cnt  output  CNT_WIDTH  accepted reads, saturating.
- wr_cnt  output  CNT_WIDTH  accepted writes, saturating.
- err_oor  output  1  sticky flag: an access hit an address >= MEM_DEPTH.

Behaviour:
- Reset (srstn=0, asynchronous):
  - data_in=0, dram_valid=0, rd_cnt=0, wr_cnt=0, err_oor=0.
  - The read pipeline is flushed: all valid stages and data stages go to 0.
  - Memory array contents are not reset and are preserved across reset.
- Reset mid-operation: in-flight reads are discarded and no dram_valid pulse follows reset release.
- Read:
  - Request in cycle N with dram_en_rd=1 gives data_in=mem[addr_in] and dram_valid=1 in cycle N+RD_LAT.
  - Back-to-back reads are accepted every cycle (full throughput, no stall). Each read produces exactly one valid cycle, in order.
  - When no response is due, dram_valid=0 and data_in holds its last value.
  - With RD_LAT=1: data_in is registered from the array read; dram_valid is dram_en_rd delayed by one flop.
  - With RD_LAT>1: extra flop stages on both data and valid.
- Write:
  - dram_en_wr=1 in cycle N gives mem[addr_out]=data_out at the rising edge ending cycle N.
  - No response is generated for a write.
- Simultaneous read and write:
  - Both are accepted in the same cycle.
  - When addr_in != addr_out, the two are independent.
  - When addr_in == addr_out, see Optional Feature.
- Out-of-range (address >= MEM_DEPTH):
  - A read returns 0 and still asserts dram_valid on schedule.
  - A write is dropped; memory is unchanged.
  - Either case sets err_oor=1 on the next cycle. err_oor stays set until clr_cnt or reset.
  - Out-of-range accesses are still counted.
- Counters:
  - rd_cnt increments by 1 per accepted read; wr_cnt increments by 1 per accepted write.
  - Both can increment in the same cycle.
  - Each saturates at 2^CNT_WIDTH-1 and never wraps.
  - clr_cnt=1 forces both counters and err_oor to 0 on the next edge. clr_cnt has priority over a same-cycle increment and over a same-cycle err_oor set.
- Read pipeline is a shift structure of RD_LAT stages. There is no FSM; only the counters and the error flag have internal state beyond the array.
- Illegal RD_LAT (0 or >4): elaboration error.

Optional Feature:
- Macro: DRAM_RESP_FWD_EN.
- Defined: read-after-write forwarding. When dram_en_rd and dram_en_wr are both 1 in the same cycle and addr_in==addr_out (in range), the read returns data_out of that cycle, i.e. the new data.
- Undefined: the same collision returns the old mem contents (read-before-write). The write still commits.
- In both builds, later reads to that address return the new data.

Test Plan:
- Reset release, then write 0x0000000A @0, 0x0000000A @1, 0x00000010 @2. Read 0,1,2 back-to-back -> with RD_LAT=1, dram_valid high for 3 consecutive cycles starting 1 cycle after the first read; data_in = 0xA, 0xA, 0x10.
- Preload 0xFFFFFFF0 @61504. Read 61504 while writing 0x5 @131072 in the same cycle -> data_in=0xFFFFFFF0; a later read @131072 returns 0x5; rd_cnt=2, wr_cnt=1.
- Same-cycle write 0x1234 and read @131080, where the address previously held 0x99 -> data_in=0x1234 with DRAM_RESP_FWD_EN defined, 0x99 without; a following read returns 0x1234 in both builds.
- RD_LAT=3: issue reads in cycles 10 and 11 -> dram_valid in cycles 13 and 14 only. Assert srstn=0 in cycle 12 -> no dram_valid after release; data_in=0.
- Read @200000 (>= MEM_DEPTH) -> data_in=0, dram_valid=1 on schedule, err_oor=1 next cycle. Write @200000 -> memory unchanged. Pulse clr_cnt -> err_oor=0, rd_cnt=0, wr_cnt=0.
- CNT_WIDTH=4: 20 reads -> rd_cnt stops at 15. clr_cnt asserted in the same cycle as a read -> rd_cnt=0.
